// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_pkg
// Purpose  : Shared definitions for the machine-mode CSR file: CSR addresses,
//            CSR operation encoding, trap cause codes, mstatus bit positions
//            and the counter next-value helper.
// Revision : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // Implemented CSR addresses
    localparam logic [11:0] c_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_ADDR_MIE       = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] c_ADDR_MCOUNTINH = 12'h320;
    localparam logic [11:0] c_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] c_ADDR_MIP       = 12'h344;
    localparam logic [11:0] c_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Interrupt cause codes (platform lines start at 16)
    localparam logic [4:0] c_CAUSE_MSI       = 5'd3;
    localparam logic [4:0] c_CAUSE_MTI       = 5'd7;
    localparam logic [4:0] c_CAUSE_MEI       = 5'd11;
    localparam logic [4:0] c_CAUSE_PLAT_BASE = 5'd16;

    // mstatus bit positions
    localparam int c_MSTATUS_MIE  = 3;
    localparam int c_MSTATUS_MPIE = 7;

    // Counter next value, held in a 64-bit container regardless of the real
    // counter width. A CSR write to either half replaces that half and
    // suppresses the increment for that cycle.
    function automatic logic [63:0] cnt_next(
        input logic [63:0] old_val,
        input logic        inc_en,
        input logic        wr_lo,
        input logic        wr_hi,
        input logic [31:0] wdata
    );
        logic [63:0] nxt;
        nxt = old_val;
        if (wr_lo) begin
            nxt = {old_val[63:32], wdata};
        end else if (wr_hi) begin
            nxt = {wdata, old_val[31:0]};
        end else if (inc_en) begin
            nxt = old_val + 64'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_irq_prio.sv
`default_nettype none
// ============================================================================
// Module   : csr_irq_prio
// Purpose  : Combinational trap-cause priority encoder.
//            Order: synchronous exception > MEI > MSI > MTI > platform lines
//            (lowest index wins).
// Ports    : i_exc_valid/i_exc_code - synchronous exception and its code
//            i_mei/i_msi/i_mti      - enabled & pending standard interrupts
//            i_plat                 - enabled & pending platform interrupts
//            o_valid/o_is_irq/o_code - selected cause
// Revision : 1.0 - initial release
// ============================================================================
module csr_irq_prio
    import csr_pkg::*;
#(
    parameter int NUM_PLAT_IRQ = 16
) (
    input  logic                    i_exc_valid,
    input  logic [4:0]              i_exc_code,
    input  logic                    i_mei,
    input  logic                    i_msi,
    input  logic                    i_mti,
    input  logic [NUM_PLAT_IRQ-1:0] i_plat,
    output logic                    o_valid,
    output logic                    o_is_irq,
    output logic [4:0]              o_code
);

    logic       w_plat_valid;
    logic [4:0] w_plat_code;

    // Scan from the top down so the lowest pending index is the last writer.
    always_comb begin
        w_plat_valid = 1'b0;
        w_plat_code  = 5'd0;
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
            if (i_plat[i]) begin
                w_plat_valid = 1'b1;
                w_plat_code  = c_CAUSE_PLAT_BASE + 5'(i);
            end
        end
    end

    always_comb begin
        o_valid  = 1'b1;
        o_is_irq = 1'b1;
        o_code   = 5'd0;
        if (i_exc_valid) begin
            o_is_irq = 1'b0;
            o_code   = i_exc_code;
        end else if (i_mei) begin
            o_code = c_CAUSE_MEI;
        end else if (i_msi) begin
            o_code = c_CAUSE_MSI;
        end else if (i_mti) begin
            o_code = c_CAUSE_MTI;
        end else if (w_plat_valid) begin
            o_code = w_plat_code;
        end else begin
            o_valid  = 1'b0;
            o_is_irq = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_file_m.sv
`default_nettype none
// ============================================================================
// Module   : csr_file_m
// Purpose  : Machine-mode CSR file: CSRRW/RS/RC access, synchronous exception
//            and prioritised interrupt trap entry, mret, direct/vectored
//            mtvec, mcycle/minstret counters with mcountinhibit.
// Ports    : clk, reset (async, active-high)
//            csr_en/csr_op/csr_addr/csr_wdata -> csr_rdata, illegal_csr
//            exc_valid/exc_code/exc_tval      - synchronous exception
//            irq_ext/irq_timer/irq_soft/irq_plat - interrupt levels
//            trap_take, mret_en, instr_ret, cur_pc - core control
//            irq_req, trap_target, mepc_o     - to the PC mux / core
// Revision : 1.0 - initial release
// ============================================================================
module csr_file_m
    import csr_pkg::*;
#(
    parameter int          NUM_PLAT_IRQ = 16,
    parameter int          CNT_W        = 64,
    parameter int          VECTORED_EN  = 1,
    parameter logic [31:0] RESET_MTVEC  = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    csr_en,
    input  logic [1:0]              csr_op,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    illegal_csr,
    input  logic                    exc_valid,
    input  logic [4:0]              exc_code,
    input  logic [31:0]             exc_tval,
    input  logic                    irq_ext,
    input  logic                    irq_timer,
    input  logic                    irq_soft,
    input  logic [NUM_PLAT_IRQ-1:0] irq_plat,
    input  logic                    trap_take,
    input  logic                    mret_en,
    input  logic                    instr_ret,
    input  logic [31:0]             cur_pc,
    output logic                    irq_req,
    output logic [31:0]             trap_target,
    output logic [31:0]             mepc_o
);

    localparam logic        c_HAS_HI    = (CNT_W > 32);
    localparam logic [31:0] c_PLAT_MASK = ((32'h1 << NUM_PLAT_IRQ) - 32'h1) << 16;
    localparam logic [31:0] c_MIE_MASK  = c_PLAT_MASK | 32'h0000_0888;

    // ---------------- state ----------------
    logic [31:0]      r_mip;
    logic [31:0]      r_mie;
    logic [31:0]      r_mepc;
    logic [31:0]      r_mcause;
    logic [31:0]      r_mtval;
    logic [31:0]      r_mscratch;
    logic [29:0]      r_mtvec_base;
    logic             r_mtvec_mode;
    logic             r_mstatus_mie;
    logic             r_mstatus_mpie;
    logic             r_cy_inh;
    logic             r_ir_inh;
    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;

    // ---------------- combinational ----------------
    csr_op_e     w_op;
    logic [31:0] w_mip_in;
    logic [31:0] w_mstatus;
    logic [31:0] w_mtvec;
    logic [63:0] w_mcycle64;
    logic [63:0] w_minstret64;
    logic [63:0] w_mcycle_nxt;
    logic [63:0] w_minstret_nxt;
    logic [31:0] w_rdata;
    logic        w_impl;
    logic        w_ro;
    logic        w_do_write;
    logic        w_we;
    logic [31:0] w_new;
    logic [31:0] w_pend;
    logic        w_prio_valid;
    logic        w_prio_is_irq;
    logic [4:0]  w_prio_code;
    logic [31:0] w_tvec_base;

    assign w_op = csr_op_e'(csr_op);

    always_comb begin
        w_mip_in                      = 32'h0;
        w_mip_in[11]                  = irq_ext;
        w_mip_in[7]                   = irq_timer;
        w_mip_in[3]                   = irq_soft;
        w_mip_in[16 +: NUM_PLAT_IRQ]  = irq_plat;
    end

    // MPP is hardwired to machine mode.
    assign w_mstatus    = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
    assign w_mtvec      = {r_mtvec_base, 1'b0, r_mtvec_mode};
    assign w_mcycle64   = 64'(r_mcycle);
    assign w_minstret64 = 64'(r_minstret);

    // Read mux / address decode
    always_comb begin
        w_rdata = 32'h0;
        w_impl  = 1'b1;
        w_ro    = 1'b0;
        case (csr_addr)
            c_ADDR_MSTATUS:   w_rdata = w_mstatus;
            c_ADDR_MIE:       w_rdata = r_mie;
            c_ADDR_MTVEC:     w_rdata = w_mtvec;
            c_ADDR_MCOUNTINH: w_rdata = {29'b0, r_ir_inh, 1'b0, r_cy_inh};
            c_ADDR_MSCRATCH:  w_rdata = r_mscratch;
            c_ADDR_MEPC:      w_rdata = r_mepc;
            c_ADDR_MCAUSE:    w_rdata = r_mcause;
            c_ADDR_MTVAL:     w_rdata = r_mtval;
            c_ADDR_MIP: begin
                w_rdata = r_mip;
                w_ro    = 1'b1;
            end
            c_ADDR_MCYCLE:    w_rdata = w_mcycle64[31:0];
            c_ADDR_MINSTRET:  w_rdata = w_minstret64[31:0];
            c_ADDR_MCYCLEH: begin
                w_rdata = c_HAS_HI ? w_mcycle64[63:32] : 32'h0;
                w_impl  = c_HAS_HI;
            end
            c_ADDR_MINSTRETH: begin
                w_rdata = c_HAS_HI ? w_minstret64[63:32] : 32'h0;
                w_impl  = c_HAS_HI;
            end
            default: w_impl = 1'b0;
        endcase
    end

    // Set/clear with a zero mask is a pure read and never counts as a write.
    assign w_do_write  = (w_op == CSR_OP_RW) ||
                         (((w_op == CSR_OP_RS) || (w_op == CSR_OP_RC)) && (csr_wdata != 32'h0));
    assign illegal_csr = csr_en && (!w_impl || (w_do_write && w_ro));
    assign w_we        = csr_en && w_do_write && !illegal_csr && !trap_take && !mret_en;
    assign csr_rdata   = w_rdata;

    always_comb begin
        case (w_op)
            CSR_OP_RW: w_new = csr_wdata;
            CSR_OP_RS: w_new = w_rdata | csr_wdata;
            CSR_OP_RC: w_new = w_rdata & ~csr_wdata;
            default:   w_new = w_rdata;
        endcase
    end

    // ---------------- trap cause and target ----------------
    assign w_pend  = r_mip & r_mie;
    assign irq_req = r_mstatus_mie && (w_pend != 32'h0);

    csr_irq_prio #(
        .NUM_PLAT_IRQ (NUM_PLAT_IRQ)
    ) u_prio (
        .i_exc_valid (exc_valid),
        .i_exc_code  (exc_code),
        .i_mei       (w_pend[11]),
        .i_msi       (w_pend[3]),
        .i_mti       (w_pend[7]),
        .i_plat      (w_pend[16 +: NUM_PLAT_IRQ]),
        .o_valid     (w_prio_valid),
        .o_is_irq    (w_prio_is_irq),
        .o_code      (w_prio_code)
    );

    assign w_tvec_base = {r_mtvec_base, 2'b00};
    assign trap_target = (w_prio_valid && w_prio_is_irq && r_mtvec_mode)
                       ? (w_tvec_base + {25'b0, w_prio_code, 2'b00})
                       : w_tvec_base;
    assign mepc_o      = r_mepc;

    // ---------------- counters ----------------
    assign w_mcycle_nxt   = cnt_next(w_mcycle64, !r_cy_inh,
                                     w_we && (csr_addr == c_ADDR_MCYCLE),
                                     w_we && (csr_addr == c_ADDR_MCYCLEH), w_new);
    assign w_minstret_nxt = cnt_next(w_minstret64, instr_ret && !r_ir_inh,
                                     w_we && (csr_addr == c_ADDR_MINSTRET),
                                     w_we && (csr_addr == c_ADDR_MINSTRETH), w_new);

    // ---------------- state update ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mip          <= 32'h0;
            r_mie          <= 32'h0;
            r_mepc         <= 32'h0;
            r_mcause       <= 32'h0;
            r_mtval        <= 32'h0;
            r_mscratch     <= 32'h0;
            r_mtvec_base   <= RESET_MTVEC[31:2];
            r_mtvec_mode   <= (VECTORED_EN != 0) && (RESET_MTVEC[1:0] == 2'b01);
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_cy_inh       <= 1'b0;
            r_ir_inh       <= 1'b0;
            r_mcycle       <= '0;
            r_minstret     <= '0;
        end else begin
            r_mip      <= w_mip_in;
            r_mcycle   <= w_mcycle_nxt[CNT_W-1:0];
            r_minstret <= w_minstret_nxt[CNT_W-1:0];

            if (w_we && (csr_addr == c_ADDR_MIE)) begin
                r_mie <= w_new & c_MIE_MASK;
            end
            if (w_we && (csr_addr == c_ADDR_MTVEC)) begin
                r_mtvec_base <= w_new[31:2];
                // Only direct and vectored modes exist; anything else is direct.
                r_mtvec_mode <= (VECTORED_EN != 0) && (w_new[1:0] == 2'b01);
            end
            if (w_we && (csr_addr == c_ADDR_MSCRATCH)) begin
                r_mscratch <= w_new;
            end
            if (w_we && (csr_addr == c_ADDR_MCOUNTINH)) begin
                r_cy_inh <= w_new[0];
                r_ir_inh <= w_new[2];
            end

            // w_we is already low whenever trap_take or mret_en is high.
            if (trap_take) begin
                r_mepc         <= cur_pc & ~32'h3;
                r_mcause       <= {w_prio_is_irq, 26'b0, w_prio_code};
                r_mtval        <= exc_valid ? exc_tval : 32'h0;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret_en) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else begin
                if (w_we && (csr_addr == c_ADDR_MSTATUS)) begin
                    r_mstatus_mie  <= w_new[c_MSTATUS_MIE];
                    r_mstatus_mpie <= w_new[c_MSTATUS_MPIE];
                end
                if (w_we && (csr_addr == c_ADDR_MEPC)) begin
                    r_mepc <= w_new & ~32'h3;
                end
                if (w_we && (csr_addr == c_ADDR_MCAUSE)) begin
                    r_mcause <= w_new;
                end
                if (w_we && (csr_addr == c_ADDR_MTVAL)) begin
                    r_mtval <= w_new;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_file_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file_m
// Purpose  : Self-checking bench for csr_file_m: a table of CSR accesses with
//            hand-computed old values / illegal flags, followed by directed
//            sequences for traps, interrupts, vectoring, precedence,
//            counters and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file_m;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_tval;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_soft;
    logic [15:0] irq_plat;
    logic        trap_take;
    logic        mret_en;
    logic        instr_ret;
    logic [31:0] cur_pc;
    logic        irq_req;
    logic [31:0] trap_target;
    logic [31:0] mepc_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] NONE = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

    csr_file_m #(
        .NUM_PLAT_IRQ (16),
        .CNT_W        (64),
        .VECTORED_EN  (1),
        .RESET_MTVEC  (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_en      (csr_en),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .illegal_csr (illegal_csr),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .exc_tval    (exc_tval),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .irq_soft    (irq_soft),
        .irq_plat    (irq_plat),
        .trap_take   (trap_take),
        .mret_en     (mret_en),
        .instr_ret   (instr_ret),
        .cur_pc      (cur_pc),
        .irq_req     (irq_req),
        .trap_target (trap_target),
        .mepc_o      (mepc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [29];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CSR access; old value and illegal flag sampled mid-cycle.
    task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic ill);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        @(negedge clk);
        rd  = csr_rdata;
        ill = illegal_csr;
        @(posedge clk);
        #1;
        csr_en    = 1'b0;
        csr_op    = NONE;
        csr_wdata = 32'h0;
    endtask

    task automatic csr_rd_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ill;
        csr_do(NONE, addr, 32'h0, rd, ill);
        check32(name, rd, exp);
    endtask

    task automatic set_mcycle_allf();
        logic [31:0] rd;
        logic        ill;
        csr_do(RW, 12'h320, 32'h1, rd, ill);
        csr_do(RW, 12'hB00, 32'hFFFF_FFFF, rd, ill);
        csr_do(RW, 12'hB80, 32'hFFFF_FFFF, rd, ill);
        csr_do(RW, 12'h320, 32'h0, rd, ill);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ill;

        vecs[0]  = '{RW,   12'h340, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{RS,   12'h340, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{NONE, 12'h340, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{RC,   12'h340, 32'h0000_00FF, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{RS,   12'h340, 32'h0000_0011, 32'hDEAD_BE00, 1'b0};
        vecs[5]  = '{NONE, 12'h340, 32'h0000_0000, 32'hDEAD_BE11, 1'b0};
        vecs[6]  = '{RW,   12'h344, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[7]  = '{NONE, 12'h344, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{RS,   12'h344, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{RC,   12'h344, 32'h0000_00FF, 32'h0000_0000, 1'b1};
        vecs[10] = '{NONE, 12'h300, 32'h0000_0000, 32'h0000_1800, 1'b0};
        vecs[11] = '{RW,   12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0};
        vecs[12] = '{RC,   12'h300, 32'h0000_0008, 32'h0000_1888, 1'b0};
        vecs[13] = '{RW,   12'h300, 32'h0000_0000, 32'h0000_1880, 1'b0};
        vecs[14] = '{RW,   12'h304, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[15] = '{RW,   12'h304, 32'h0000_0000, 32'hFFFF_0888, 1'b0};
        vecs[16] = '{RW,   12'h305, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[17] = '{RW,   12'h305, 32'h0000_1001, 32'hFFFF_FFFC, 1'b0};
        vecs[18] = '{RW,   12'h305, 32'h0000_0000, 32'h0000_1001, 1'b0};
        vecs[19] = '{RW,   12'h341, 32'h0000_1003, 32'h0000_0000, 1'b0};
        vecs[20] = '{NONE, 12'h341, 32'h0000_0000, 32'h0000_1000, 1'b0};
        vecs[21] = '{RW,   12'h320, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[22] = '{RW,   12'h320, 32'h0000_0000, 32'h0000_0005, 1'b0};
        vecs[23] = '{NONE, 12'h7C0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[24] = '{NONE, 12'hB80, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[25] = '{RW,   12'h343, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[26] = '{NONE, 12'h343, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[27] = '{RW,   12'h342, 32'h8000_000B, 32'h0000_0000, 1'b0};
        vecs[28] = '{NONE, 12'h342, 32'h0000_0000, 32'h8000_000B, 1'b0};

        reset = 1'b1;
        csr_en = 1'b0; csr_op = NONE; csr_addr = 12'h0; csr_wdata = 32'h0;
        exc_valid = 1'b0; exc_code = 5'd0; exc_tval = 32'h0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; irq_plat = 16'h0;
        trap_take = 1'b0; mret_en = 1'b0; instr_ret = 1'b0; cur_pc = 32'h0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset_mepc_o", mepc_o, 32'h0);
        check32("reset_trap_target", trap_target, 32'h0);
        check32("reset_irq_req", {31'b0, irq_req}, 32'h0);
        check32("reset_illegal", {31'b0, illegal_csr}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ---- table-driven CSR accesses ----
        for (int i = 0; i < 29; i++) begin
            csr_do(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, ill);
            check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check32($sformatf("vec%0d_illegal", i), {31'b0, ill}, {31'b0, vecs[i].exp_ill});
        end

        // ---- timer interrupt, trap entry, mret ----
        csr_do(RW, 12'h300, 32'h0000_0008, rd, ill);
        csr_do(RW, 12'h304, 32'h0000_0080, rd, ill);
        irq_timer = 1'b1;
        @(negedge clk);
        check32("irq_req_not_yet", {31'b0, irq_req}, 32'h0);
        @(posedge clk);
        #1;
        check32("irq_req_after_1cyc", {31'b0, irq_req}, 32'h1);
        trap_take = 1'b1;
        cur_pc    = 32'h0000_2006;
        @(negedge clk);
        check32("tgt_direct_irq", trap_target, 32'h0);
        @(posedge clk);
        #1;
        trap_take = 1'b0;
        irq_timer = 1'b0;
        check32("irq_req_after_trap", {31'b0, irq_req}, 32'h0);
        csr_rd_check("mti_mcause", 12'h342, 32'h8000_0007);
        csr_rd_check("mti_mstatus", 12'h300, 32'h0000_1880);
        csr_rd_check("mti_mepc", 12'h341, 32'h0000_2004);
        csr_rd_check("mti_mtval", 12'h343, 32'h0000_0000);
        check32("mepc_o_after_trap", mepc_o, 32'h0000_2004);
        mret_en = 1'b1;
        @(posedge clk);
        #1 mret_en = 1'b0;
        csr_rd_check("mret_mstatus", 12'h300, 32'h0000_1888);

        // ---- vectored mtvec and cause priority ----
        csr_do(RW, 12'h305, 32'h0000_1001, rd, ill);
        csr_do(RW, 12'h304, 32'hFFFF_FFFF, rd, ill);
        irq_ext = 1'b1; irq_soft = 1'b1; irq_timer = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check32("tgt_vec_mei", trap_target, 32'h0000_102C);
        check32("irq_req_mei", {31'b0, irq_req}, 32'h1);
        exc_valid = 1'b1; exc_code = 5'd2;
        #1;
        check32("tgt_vec_exc", trap_target, 32'h0000_1000);
        exc_valid = 1'b0;
        irq_ext = 1'b0;
        @(posedge clk);
        #1;
        check32("tgt_msi_over_mti", trap_target, 32'h0000_100C);
        irq_soft = 1'b0; irq_timer = 1'b0; irq_plat = 16'h0028;
        @(posedge clk);
        #1;
        check32("tgt_plat_lowest", trap_target, 32'h0000_104C);
        irq_plat = 16'h8000;
        @(posedge clk);
        #1;
        check32("tgt_plat_top", trap_target, 32'h0000_107C);
        irq_plat = 16'h0;
        @(posedge clk);
        #1;

        // ---- same-cycle trap + mret + CSR write ----
        trap_take = 1'b1; mret_en = 1'b1;
        csr_en = 1'b1; csr_op = RW; csr_addr = 12'h340; csr_wdata = 32'hAAAA_5555;
        exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'hBAD0_0BAD; cur_pc = 32'h0000_3000;
        @(negedge clk);
        check32("tgt_exc_vectored", trap_target, 32'h0000_1000);
        @(posedge clk);
        #1;
        trap_take = 1'b0; mret_en = 1'b0; csr_en = 1'b0; csr_op = NONE;
        exc_valid = 1'b0; exc_tval = 32'h0;
        csr_rd_check("prec_mscratch", 12'h340, 32'hDEAD_BE11);
        csr_rd_check("prec_mcause", 12'h342, 32'h0000_0002);
        csr_rd_check("prec_mtval", 12'h343, 32'hBAD0_0BAD);
        csr_rd_check("prec_mepc", 12'h341, 32'h0000_3000);
        csr_rd_check("prec_mstatus", 12'h300, 32'h0000_1880);
        // mret beats a CSR write to mstatus
        mret_en = 1'b1;
        csr_do(RW, 12'h300, 32'h0000_0000, rd, ill);
        mret_en = 1'b0;
        csr_rd_check("mret_over_csr", 12'h300, 32'h0000_1888);

        // ---- mcycle wrap and write-wins ----
        set_mcycle_allf();
        csr_rd_check("mcycle_allf", 12'hB00, 32'hFFFF_FFFF);
        csr_rd_check("mcycle_wrap_lo", 12'hB00, 32'h0000_0000);
        csr_rd_check("mcycle_wrap_hi", 12'hB80, 32'h0000_0000);
        set_mcycle_allf();
        csr_do(RW, 12'hB00, 32'h0000_0055, rd, ill);
        check32("mcycle_pre_write", rd, 32'hFFFF_FFFF);
        csr_rd_check("mcycle_write_wins", 12'hB00, 32'h0000_0055);

        // ---- minstret and inhibit ----
        csr_do(RW, 12'hB02, 32'h0, rd, ill);
        instr_ret = 1'b1;
        repeat (3) @(posedge clk);
        #1 instr_ret = 1'b0;
        csr_rd_check("minstret_3", 12'hB02, 32'h0000_0003);
        csr_do(RW, 12'h320, 32'h0000_0004, rd, ill);
        instr_ret = 1'b1;
        repeat (2) @(posedge clk);
        #1 instr_ret = 1'b0;
        csr_rd_check("minstret_inhibit", 12'hB02, 32'h0000_0003);
        csr_do(RW, 12'h320, 32'h0, rd, ill);

        // ---- asynchronous reset in the middle of a trap ----
        trap_take = 1'b1; exc_valid = 1'b1; exc_code = 5'd4; cur_pc = 32'h0000_4444;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("async_mepc_o", mepc_o, 32'h0);
        check32("async_trap_target", trap_target, 32'h0);
        check32("async_irq_req", {31'b0, irq_req}, 32'h0);
        @(posedge clk);
        #1;
        trap_take = 1'b0; exc_valid = 1'b0; reset = 1'b0;
        csr_rd_check("rst_mscratch", 12'h340, 32'h0);
        csr_rd_check("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_rd_check("rst_mtvec", 12'h305, 32'h0);
        csr_rd_check("rst_mcause", 12'h342, 32'h0);
        csr_rd_check("rst_mtval", 12'h343, 32'h0);
        csr_rd_check("rst_mie", 12'h304, 32'h0);
        csr_rd_check("rst_mepc", 12'h341, 32'h0);
        csr_rd_check("rst_minstret", 12'hB02, 32'h0);
        csr_rd_check("rst_mcycleh", 12'hB80, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
